// File: rtl/rm_mon_pkg.sv
// Shared constants and event record for the LTL monitor violation collector.
// Default widths here describe one standard monitor cluster.
package rm_mon_pkg;

    localparam int NUM_PROP_C7 = 9;
    localparam int TS_W_C      = 32;
    localparam int ID_W_C      = $clog2(NUM_PROP_C7);

    typedef struct packed {
        logic [ID_W_C-1:0] prop;
        logic [TS_W_C-1:0] ts;
    } rm_evt_t;

endpackage

// File: rtl/rm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among pending requests, search starts
// one past the most recent grant (index 0 after reset).
module rm_rr_arbiter #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;

    // Scan from the farthest candidate back to ptr so the nearest request wins.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        ptr_next = ptr;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    ptr_next   = PW'((idx + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) ptr <= '0;
        else        ptr <= ptr_next;
    end

endmodule

// File: rtl/rm_violation_collector.sv
// Collects rising edges of per-property LTL hit flags, timestamps and counts
// them, and queues {prop, ts} events through a small FIFO for the debug unit.
module rm_violation_collector
    import rm_mon_pkg::*;
#(
    parameter int NUM_PROP = NUM_PROP_C7,
    parameter int TS_W     = TS_W_C,
    parameter int CNT_W    = 16,
    parameter int DEPTH    = 8,
    parameter int ID_W     = $clog2(NUM_PROP)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     clear,
    input  logic [NUM_PROP-1:0]      ltl_hit,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [ID_W-1:0]          evt_prop,
    output logic [TS_W-1:0]          evt_time,
    output logic [NUM_PROP-1:0]      sticky,
    output logic                     any_hit,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   fifo_level,
    input  logic [ID_W-1:0]          cnt_sel,
    output logic [CNT_W-1:0]         cnt_val
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0] prop;
        logic [TS_W-1:0] ts;
    } evt_t;

    logic [TS_W-1:0]     ts;
    logic [NUM_PROP-1:0] hit_prev;
    logic [NUM_PROP-1:0] rise;
    logic [NUM_PROP-1:0] pend;
    logic [NUM_PROP-1:0] grant;
    logic [NUM_PROP-1:0] sticky_q;
    logic                overrun_q;
    logic [TS_W-1:0]     pend_ts [NUM_PROP];
    logic [CNT_W-1:0]    cnt     [NUM_PROP];

    evt_t                mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic                full;
    logic                push;
    logic                pop;
    logic [ID_W-1:0]     grant_idx;

    assign rise = ltl_hit & ~hit_prev & {NUM_PROP{run}};
    assign full = (level == LVL_W'(DEPTH));
    assign push = |grant;
    assign pop  = evt_valid & evt_ready;

    // No grants during clear so the round-robin pointer survives it untouched.
    rm_rr_arbiter #(.N(NUM_PROP)) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (!full && !clear),
        .req   (pend),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PROP; i++) begin
            if (grant[i]) grant_idx = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) hit_prev <= '0;
        else        hit_prev <= ltl_hit;
    end

    // A rise on a slot still waiting merges into the older event and flags overrun.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            ts        <= '0;
            pend      <= '0;
            sticky_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_PROP; i++) begin
                pend_ts[i] <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            if (run) ts <= ts + TS_W'(1);
            for (int i = 0; i < NUM_PROP; i++) begin
                if (rise[i]) begin
                    pend[i]     <= 1'b1;
                    sticky_q[i] <= 1'b1;
                    if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
                    if (pend[i] && !grant[i]) overrun_q  <= 1'b1;
                    else                      pend_ts[i] <= ts;
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{prop: grant_idx, ts: pend_ts[grant_idx]};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        cnt_val = '0;
        if (int'(cnt_sel) < NUM_PROP) cnt_val = cnt[cnt_sel];
    end

    assign evt_valid  = (level != '0);
    assign evt_prop   = mem[rd_ptr].prop;
    assign evt_time   = mem[rd_ptr].ts;
    assign fifo_level = level;
    assign sticky     = sticky_q;
    assign any_hit    = |sticky_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rm_violation_collector.sv
// Directed bench for rm_violation_collector: a default-width instance plus a
// narrow one (4-bit counters and timestamps) for saturation and wrap behaviour.
module tb_rm_violation_collector;

    logic        clk = 1'b0;
    logic        reset;

    logic        run, clear, evt_ready;
    logic [8:0]  ltl_hit;
    logic [3:0]  cnt_sel;
    logic        evt_valid, any_hit, overrun;
    logic [3:0]  evt_prop;
    logic [31:0] evt_time;
    logic [8:0]  sticky;
    logic [3:0]  fifo_level;
    logic [15:0] cnt_val;

    logic        run_s, clear_s, evt_ready_s;
    logic [8:0]  ltl_hit_s;
    logic [3:0]  cnt_sel_s;
    logic        evt_valid_s, any_hit_s, overrun_s;
    logic [3:0]  evt_prop_s;
    logic [3:0]  evt_time_s;
    logic [8:0]  sticky_s;
    logic [3:0]  fifo_level_s;
    logic [3:0]  cnt_val_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rm_violation_collector u_dut (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .ltl_hit(ltl_hit),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_prop(evt_prop),
        .evt_time(evt_time), .sticky(sticky), .any_hit(any_hit), .overrun(overrun),
        .fifo_level(fifo_level), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    rm_violation_collector #(.TS_W(4), .CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .run(run_s), .clear(clear_s), .ltl_hit(ltl_hit_s),
        .evt_valid(evt_valid_s), .evt_ready(evt_ready_s), .evt_prop(evt_prop_s),
        .evt_time(evt_time_s), .sticky(sticky_s), .any_hit(any_hit_s), .overrun(overrun_s),
        .fifo_level(fifo_level_s), .cnt_sel(cnt_sel_s), .cnt_val(cnt_val_s)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] hits);
        ltl_hit = hits;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; run = 1'b1; clear = 1'b0; evt_ready = 1'b0; ltl_hit = 9'h1FF; cnt_sel = 4'd0;
        run_s = 1'b1; clear_s = 1'b0; evt_ready_s = 1'b1; ltl_hit_s = 9'h000; cnt_sel_s = 4'd0;
        repeat (3) tick();
        checkOutput("rst_valid",   evt_valid,  0);
        checkOutput("rst_prop",    evt_prop,   0);
        checkOutput("rst_time",    evt_time,   0);
        checkOutput("rst_sticky",  sticky,     0);
        checkOutput("rst_anyhit",  any_hit,    0);
        checkOutput("rst_overrun", overrun,    0);
        checkOutput("rst_level",   fifo_level, 0);
        checkOutput("rst_cnt",     cnt_val,    0);

        ltl_hit = 9'h000;
        reset   = 1'b1;
        repeat (3) tick();
        checkOutput("post_rst_sticky", sticky,    0);
        checkOutput("post_rst_valid",  evt_valid, 0);

        // Simultaneous rises at ts=5 drain in index order 0..8.
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (5) tick();
        evt_ready = 1'b1;
        applyStimulus(9'h1FF);
        checkOutput("sim_latency", evt_valid, 0);
        tick();
        for (int k = 0; k < 9; k++) begin
            checkOutput("sim_valid", evt_valid,  1);
            checkOutput("sim_prop",  evt_prop,   k);
            checkOutput("sim_time",  evt_time,   5);
            checkOutput("sim_level", fifo_level, 1);
            tick();
        end
        checkOutput("sim_empty",   evt_valid,  0);
        checkOutput("sim_level0",  fifo_level, 0);
        checkOutput("sim_overrun", overrun,    0);
        checkOutput("sim_sticky",  sticky,     9'h1FF);
        cnt_sel = 4'd8; #1;
        checkOutput("sim_cnt8", cnt_val, 1);

        // Single rise on prop 3 at ts=10.
        evt_ready = 1'b0;
        applyStimulus(9'h000);
        clear = 1'b1; tick(); clear = 1'b0;
        checkOutput("clr_sticky", sticky,  0);
        checkOutput("clr_anyhit", any_hit, 0);
        repeat (10) tick();
        applyStimulus(9'h008);
        checkOutput("single_t1", evt_valid, 0);
        tick();
        checkOutput("single_valid",  evt_valid,  1);
        checkOutput("single_prop",   evt_prop,   3);
        checkOutput("single_time",   evt_time,   10);
        checkOutput("single_sticky", sticky,     9'h008);
        checkOutput("single_level",  fifo_level, 1);
        cnt_sel = 4'd3; #1;
        checkOutput("single_cnt3", cnt_val, 1);
        cnt_sel = 4'd9; #1;
        checkOutput("cnt_sel_oob", cnt_val, 0);
        tick();
        checkOutput("stall_prop",  evt_prop,   3);
        checkOutput("stall_time",  evt_time,   10);
        checkOutput("stall_level", fifo_level, 1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        checkOutput("single_pop", evt_valid, 0);

        // Backpressure: props 0..8 rise at ts 0..8, FIFO fills, prop 8 held.
        applyStimulus(9'h000);
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(ltl_hit | (9'h001 << i));
        repeat (2) tick();
        checkOutput("bp_level",   fifo_level, 8);
        checkOutput("bp_head",    evt_prop,   0);
        checkOutput("bp_overrun0", overrun,   0);
        applyStimulus(9'h0FF);
        applyStimulus(9'h1FF);
        checkOutput("bp_overrun1", overrun, 1);
        evt_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            checkOutput("bp_valid", evt_valid, 1);
            checkOutput("bp_prop",  evt_prop,  k);
            checkOutput("bp_time",  evt_time,  k);
            tick();
        end
        checkOutput("bp_empty", fifo_level, 0);

        // Clear coincident with a rise, then a pulse while run=0.
        applyStimulus(9'h000);
        clear = 1'b1; ltl_hit = 9'h004; tick(); clear = 1'b0;
        checkOutput("clrrise_sticky",  sticky,     0);
        checkOutput("clrrise_overrun", overrun,    0);
        checkOutput("clrrise_level",   fifo_level, 0);
        cnt_sel = 4'd2; #1;
        checkOutput("clrrise_cnt2", cnt_val, 0);
        repeat (2) tick();
        checkOutput("clrrise_valid", evt_valid, 0);
        run = 1'b0;
        applyStimulus(9'h000);
        applyStimulus(9'h020);
        applyStimulus(9'h000);
        repeat (2) tick();
        checkOutput("norun_valid",  evt_valid, 0);
        checkOutput("norun_sticky", sticky,    0);
        run = 1'b1; evt_ready = 1'b0;
        applyStimulus(9'h001);
        tick();
        checkOutput("frozen_valid", evt_valid, 1);
        checkOutput("frozen_prop",  evt_prop,  0);
        checkOutput("frozen_time",  evt_time,  2);

        // Narrow instance: counter saturation at 15.
        for (int p = 0; p < 20; p++) begin
            ltl_hit_s = 9'h001; tick();
            ltl_hit_s = 9'h000; tick();
            if (p == 13) checkOutput("sat_cnt14", cnt_val_s, 14);
        end
        repeat (3) tick();
        checkOutput("sat_cnt15",  cnt_val_s,    15);
        checkOutput("sat_drained", fifo_level_s, 0);

        // Narrow instance: timestamp wraps 15 -> 0.
        evt_ready_s = 1'b0;
        clear_s = 1'b1; tick(); clear_s = 1'b0;
        repeat (15) tick();
        ltl_hit_s = 9'h002; tick();
        ltl_hit_s = 9'h006; tick();
        tick();
        checkOutput("wrap_level", fifo_level_s, 2);
        checkOutput("wrap_prop1", evt_prop_s,   1);
        checkOutput("wrap_time15", evt_time_s,  15);
        evt_ready_s = 1'b1; tick(); evt_ready_s = 1'b0;
        checkOutput("wrap_prop2", evt_prop_s, 2);
        checkOutput("wrap_time0", evt_time_s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
